noc_pe_iface: RTL and testbench

NOC_PE_IFACE -- requirements
Module: noc_pe_iface

---
 rtl/noc_pe_iface.sv | 216 +++++++++++++++++++++
 tb/tb_noc_pe_iface.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pe_iface.sv
// noc_pe_iface: processing-element network interface for a 2D mesh NoC.
// Injection side: one PE result fans out as num_dest flits, one per entry in
// dest_list, delivered to the switch local input under valid/ready.
// Ejection side: flits from the switch local output addressed to this node are
// queued in a small FIFO for the PE; flits addressed elsewhere are dropped.
// Optional feature macro: NOC_PE_IFACE_MISROUTE_CNT_EN enables a saturating
// counter of dropped misrouted flits (otherwise misroute_cnt reads 0).
module noc_pe_iface #(
   parameter int                  x_size      = 2,
   parameter int                  y_size      = 2,
   parameter logic [x_size-1:0]   x_coord     = 2'b01,
   parameter logic [y_size-1:0]   y_coord     = 2'b00,
   parameter int                  data_width  = 8,
   parameter int                  total_width = 2*x_size+2*y_size+data_width,
   parameter int                  num_dest    = 4,
   // Entry i holds {x,y} at bits [i*(x_size+y_size) +: x_size+y_size].
   // Default destinations in order: 4'h0, 4'h1, 4'h4, 4'h5.
   parameter logic [16*(x_size+y_size)-1:0] dest_list = 'h5410,
   parameter int                  fifo_depth  = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   output logic [total_width-1:0]      tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   input  logic [total_width-1:0]      rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   input  logic [data_width-1:0]       pe_res_data,
   input  logic                        pe_res_valid,
   output logic                        pe_res_ready,
   output logic [data_width-1:0]       ej_data,
   output logic [x_size+y_size-1:0]    ej_src,
   output logic                        ej_valid,
   input  logic                        ej_ready,
   output logic [7:0]                  misroute_cnt
);

   localparam int XY_W  = x_size + y_size;
   localparam int IDX_W = (num_dest > 1) ? $clog2(num_dest) : 1;
   localparam int PTR_W = $clog2(fifo_depth);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = XY_W + data_width;

   localparam logic [XY_W-1:0]  OWN_ADDR = {x_coord, y_coord};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_dest - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(fifo_depth);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   function automatic logic [XY_W-1:0] dest_of(input logic [IDX_W-1:0] idx);
      return dest_list[int'(idx)*XY_W +: XY_W];
   endfunction

   // ---------------- injection ----------------
   logic [0:0]             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [data_width-1:0]  payload_q, payload_d;
   logic                   tx_valid_q, tx_valid_d;
   logic [total_width-1:0] tx_data_q, tx_data_d;

   // Next-state for the IDLE/SEND fan-out FSM; tx_data is prepared one cycle
   // ahead so the flit leaves straight from a register.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      payload_d  = payload_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      case (state_q)
         S_IDLE: begin
            if (pe_res_valid) begin
               payload_d  = pe_res_data;
               idx_d      = '0;
               state_d    = S_SEND;
               tx_valid_d = 1'b1;
               tx_data_d  = {pe_res_data, OWN_ADDR, dest_of('0)};
            end
         end
         S_SEND: begin
            if (tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d    = S_IDLE;
                  idx_d      = '0;
                  tx_valid_d = 1'b0;
               end else begin
                  idx_d     = idx_q + 1'b1;
                  tx_data_d = {payload_q, OWN_ADDR, dest_of(idx_q + 1'b1)};
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            idx_d      = '0;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   // Injection control and outgoing flit register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Latched PE result payload reused for every destination.
   always_ff @(posedge clk) begin
      payload_q <= payload_d;
   end

   assign pe_res_ready = (state_q == S_IDLE);
   assign tx_valid     = tx_valid_q;
   assign tx_data      = tx_data_q;

   // ---------------- ejection ----------------
   logic [ENT_W-1:0]      mem_q [fifo_depth];
   logic [ENT_W-1:0]      mem_d [fifo_depth];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  fifo_full, fifo_empty;
   logic                  rx_acc, rx_match, push, pop;
   logic [XY_W-1:0]       rx_dest, rx_src;
   logic [data_width-1:0] rx_pay;

   assign rx_dest    = rx_data[XY_W-1:0];
   assign rx_src     = rx_data[2*XY_W-1:XY_W];
   assign rx_pay     = rx_data[2*XY_W +: data_width];
   assign fifo_full  = (cnt_q == FULL_CNT);
   assign fifo_empty = (cnt_q == '0);
   assign rx_ready   = !fifo_full;
   assign rx_acc     = rx_valid && rx_ready;
   assign rx_match   = (rx_dest == OWN_ADDR);
   assign push       = rx_acc && rx_match;
   assign pop        = !fifo_empty && ej_ready;

   // FIFO next-state; pointers wrap naturally because depth is a power of 2.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = {rx_src, rx_pay};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // FIFO storage; contents are only visible while occupancy is non-zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign ej_valid          = !fifo_empty;
   assign {ej_src, ej_data} = fifo_empty ? '0 : mem_q[rd_ptr_q];

`ifdef NOC_PE_IFACE_MISROUTE_CNT_EN
   logic [7:0] mis_q, mis_d;
   logic       drop;

   assign drop = rx_acc && !rx_match;

   // Saturating count of flits that arrived here but were addressed elsewhere.
   always_comb begin
      mis_d = mis_q;
      if (drop && (mis_q != 8'hFF)) begin
         mis_d = mis_q + 8'd1;
      end
   end

   // Misroute counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mis_q <= 8'h00;
      end else begin
         mis_q <= mis_d;
      end
   end

   assign misroute_cnt = mis_q;
`else
   assign misroute_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_noc_pe_iface.sv
// Testbench for noc_pe_iface (default parameters). A queue-based reference
// model tracks expected injection flits and ejection FIFO contents.
module tb_noc_pe_iface;

`ifdef NOC_PE_IFACE_MISROUTE_CNT_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif
   localparam logic [3:0] OWN = 4'h4;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  pe_res_data;
   logic        pe_res_valid;
   logic        pe_res_ready;
   logic [7:0]  ej_data;
   logic [3:0]  ej_src;
   logic        ej_valid;
   logic        ej_ready;
   logic [7:0]  misroute_cnt;

   noc_pe_iface dut (
      .clk(clk), .rstn(rstn),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .pe_res_data(pe_res_data), .pe_res_valid(pe_res_valid), .pe_res_ready(pe_res_ready),
      .ej_data(ej_data), .ej_src(ej_src), .ej_valid(ej_valid), .ej_ready(ej_ready),
      .misroute_cnt(misroute_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [11:0] fq[$];   // {src, payload}
   logic [15:0] tq[$];   // pending outgoing flits
   int          mis_exp = 0;
   logic [3:0]  dests [4] = '{4'h0, 4'h1, 4'h4, 4'h5};

   typedef struct {
      logic [15:0] rx;
      logic        exp_valid;
      logic [3:0]  exp_src;
      logic [7:0]  exp_data;
   } vec_t;
   vec_t vecs[7];

   function automatic void check(string nm, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endfunction

   // One clock: compare outputs against the model at negedge, advance the
   // model from the inputs the DUT sees on the coming posedge.
   task automatic cycle();
      logic [11:0] head;
      logic        acc;
      @(negedge clk);
      check("rx_ready", rx_ready, fq.size() < 4);
      check("ej_valid", ej_valid, fq.size() != 0);
      if (fq.size() != 0) begin
         head = fq[0];
         check("ej_src", ej_src, head[11:8]);
         check("ej_data", ej_data, head[7:0]);
      end
      check("pe_res_ready", pe_res_ready, tq.size() == 0);
      check("tx_valid", tx_valid, tq.size() != 0);
      if (tq.size() != 0) check("tx_data", tx_data, tq[0]);
      check("misroute_cnt", misroute_cnt, mis_exp);
      if (rstn) begin
         acc = rx_valid && (fq.size() < 4);
         if (fq.size() != 0 && ej_ready) void'(fq.pop_front());
         if (acc) begin
            if (rx_data[3:0] == OWN) fq.push_back({rx_data[7:4], rx_data[15:8]});
            else if (MIS_EN && mis_exp < 255) mis_exp++;
         end
         if (tq.size() != 0) begin
            if (tx_ready) void'(tq.pop_front());
         end else if (pe_res_valid) begin
            for (int i = 0; i < 4; i++) tq.push_back({pe_res_data, OWN, dests[i]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_drain();
      rx_valid = 1'b0; pe_res_valid = 1'b0; ej_ready = 1'b1; tx_ready = 1'b1;
      repeat (8) cycle();
   endtask

   initial begin
      int k;
      bit pre;
      vecs[0] = '{16'hA5B4, 1'b1, 4'hB, 8'hA5};
      vecs[1] = '{16'h3C04, 1'b1, 4'h0, 8'h3C};
      vecs[2] = '{16'h7745, 1'b0, 4'h0, 8'h00};
      vecs[3] = '{16'h1120, 1'b0, 4'h0, 8'h00};
      vecs[4] = '{16'hFFF4, 1'b1, 4'hF, 8'hFF};
      vecs[5] = '{16'h001C, 1'b0, 4'h0, 8'h00};
      vecs[6] = '{16'h5A64, 1'b1, 4'h6, 8'h5A};

      rstn = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      pe_res_data = '0; pe_res_valid = 1'b0; ej_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_ej_valid", ej_valid, 0);
      check("rst_ej_data", ej_data, 0);
      check("rst_rx_ready", rx_ready, 1);
      check("rst_pe_res_ready", pe_res_ready, 1);
      check("rst_misroute", misroute_cnt, 0);
      rstn = 1'b1;

      // misrouted flit to {2'b10,2'b11}
      rx_data = 16'h993B; rx_valid = 1'b1;
      cycle();
      rx_valid = 1'b0;
      check("misroute_one", misroute_cnt, MIS_EN ? 1 : 0);
      check("misroute_not_ejected", ej_valid, 0);

      // table-driven ejection vectors
      for (int i = 0; i < 7; i++) begin
         rx_data = vecs[i].rx; rx_valid = 1'b1; ej_ready = 1'b0;
         cycle();
         rx_valid = 1'b0;
         check("vec_ej_valid", ej_valid, vecs[i].exp_valid);
         if (vecs[i].exp_valid) begin
            check("vec_ej_src", ej_src, vecs[i].exp_src);
            check("vec_ej_data", ej_data, vecs[i].exp_data);
         end
         ej_ready = 1'b1;
         cycle();
         ej_ready = 1'b0;
      end
      check("vec_misroute_total", misroute_cnt, MIS_EN ? 4 : 0);

      // injection A5 with tx_ready held high: four flits back to back
      idle_drain();
      pe_res_data = 8'hA5; pe_res_valid = 1'b1;
      cycle();
      pe_res_valid = 1'b0;
      check("inj_first_flit", tx_data, 16'hA540);
      for (int i = 0; i < 4; i++) begin
         tx_ready = 1'b1;
         cycle();
      end
      check("inj_done_tx_valid", tx_valid, 0);
      check("inj_done_ready", pe_res_ready, 1);

      // injection with tx_ready toggling 1,0,1,0...
      pe_res_data = 8'hA5; pe_res_valid = 1'b1;
      cycle();
      pe_res_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tx_ready = (i % 2 == 0);
         cycle();
      end
      check("inj_tog_done", tx_valid, 0);

      // FIFO full: five own-address flits, drained later
      idle_drain();
      ej_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 14; c++) begin
         rx_data  = {8'hC1 + 8'(k), 4'h2, OWN};
         rx_valid = (k < 5);
         ej_ready = (c >= 6);
         pre = rx_valid && (fq.size() < 4);
         cycle();
         if (pre) k++;
         if (c == 3) begin
            check("full_rx_ready", rx_ready, 0);
            check("full_head", ej_data, 8'hC1);
         end
      end
      check("full_all_accepted", k, 5);
      check("full_drained", ej_valid, 0);

      // randomized traffic
      idle_drain();
      for (int c = 0; c < 600; c++) begin
         rx_valid     = $urandom_range(0, 1);
         rx_data      = {8'($urandom), 4'($urandom), ($urandom_range(0, 1) ? OWN : 4'($urandom))};
         ej_ready     = ($urandom_range(0, 2) != 0);
         tx_ready     = $urandom_range(0, 1);
         pe_res_valid = ($urandom_range(0, 3) == 0);
         pe_res_data  = 8'($urandom);
         cycle();
      end

      // misroute saturation
      idle_drain();
      rx_data = 16'h0000; rx_valid = 1'b1;
      repeat (270) cycle();
      rx_valid = 1'b0;
      check("misroute_sat", misroute_cnt, MIS_EN ? 255 : 0);

      // reset during second flit with two FIFO entries
      idle_drain();
      ej_ready = 1'b0; rx_data = 16'h1234; rx_valid = 1'b1; tx_ready = 1'b0;
      cycle(); cycle();
      rx_valid = 1'b0;
      pe_res_data = 8'h5E; pe_res_valid = 1'b1;
      cycle();
      pe_res_valid = 1'b0; tx_ready = 1'b1;
      cycle();
      tx_ready = 1'b0;
      cycle();
      check("pre_rst_ej_count", fq.size(), 2);
      check("pre_rst_tx_data", tx_data, 16'h5E41);
      #2 rstn = 1'b0;
      #1;
      check("arst_tx_valid", tx_valid, 0);
      check("arst_tx_data", tx_data, 0);
      check("arst_ej_valid", ej_valid, 0);
      check("arst_ej_data", ej_data, 0);
      check("arst_rx_ready", rx_ready, 1);
      check("arst_pe_res_ready", pe_res_ready, 1);
      check("arst_misroute", misroute_cnt, 0);
      fq.delete(); tq.delete(); mis_exp = 0;
      cycle(); cycle();
      rstn = 1'b1; tx_ready = 1'b1; ej_ready = 1'b1;
      repeat (6) cycle();
      check("post_rst_idle", tx_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
